pc_stack: RTL and testbench

Program counter with an integrated hardware return-address stack, sitting directly downstream of the jump-address unit. Each enabled clock it either increments the PC or loads the target address supplied by the jump unit. It also pushes or pops return addresses for CALL/RET, and presents the top-of-stack entry back to the jump unit as the link-register address used for RET-relative targets.

---
 rtl/pc_stack_if.sv | 37 +++
 rtl/pc_stack.sv | 119 +++++++++++
 tb/tb_pc_stack.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_if
// Description : Bus between the jump-address unit and the PC / return stack.
//               The jump unit (master) issues commands and a target address;
//               the PC block (slave) returns pc, link address and stack state.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic             en;
    logic             jmp_take;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] jmp_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] lr_addr;
    logic [SPW-1:0]   sp;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    modport master (
        output en, jmp_take, call, ret, jmp_addr,
        input  pc, lr_addr, sp, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  en, jmp_take, call, ret, jmp_addr,
        output pc, lr_addr, sp, stack_full, stack_empty, stack_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack
// Description : Program counter with an integrated return-address stack.
//               Increments or loads the PC each enabled cycle, pushes pc+1 on
//               CALL, pops on RET, and exposes the top entry as lr_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    pc_stack_if.slave     bus
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc_q,  pc_d;
    logic [SPW-1:0]   sp_q,  sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic             full;
    logic             empty;
    logic             push;
    logic [WIDTH-1:0] lr_sel;

    assign pc_inc = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign full   = (sp_q == SPW'(DEPTH));
    assign empty  = (sp_q == '0);

    // Command decode: call > ret > jmp_take > sequential; a squashed call or
    // ret still advances the PC and latches the sticky error.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (bus.en) begin
            if (bus.call) begin
                if (full) begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end else begin
                    push  = 1'b1;
                    sp_d  = sp_q + 1'b1;
                    pc_d  = bus.jmp_addr;
                end
            end else if (bus.ret) begin
                if (empty) begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end else begin
                    sp_d  = sp_q - 1'b1;
                    pc_d  = bus.jmp_addr;
                end
            end else if (bus.jmp_take) begin
                pc_d = bus.jmp_addr;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // PC, stack pointer and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // One register per stack slot; slot i is written only when it is the
    // next free slot. Popped entries are left stale since they are unreadable.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            // Next value of slot i: return address on a push into it.
            always_comb begin
                stack_d[i] = (push && (sp_q == SPW'(i))) ? pc_inc : stack_q[i];
            end

            // Slot i storage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stack_q[i] <= '0;
                end else begin
                    stack_q[i] <= stack_d[i];
                end
            end
        end
    endgenerate

    // Top-of-stack select, driven purely from registered state.
    always_comb begin
        lr_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) begin
                lr_sel = stack_q[i];
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.sp          = sp_q;
    assign bus.lr_addr     = lr_sel;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_stack
// Description : Self-checking bench for pc_stack: directed scenarios followed
//               by random commands, all checked against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // Reference model state
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_stk[$];
    logic             m_err;

    pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_all(input string tag);
        logic [WIDTH-1:0] e_lr;
        e_lr = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
        chk({tag, ".pc"},    32'(bus.pc),          32'(m_pc));
        chk({tag, ".sp"},    32'(bus.sp),          32'(m_stk.size()));
        chk({tag, ".lr"},    32'(bus.lr_addr),     32'(e_lr));
        chk({tag, ".full"},  32'(bus.stack_full),  32'(m_stk.size() == DEPTH));
        chk({tag, ".empty"}, 32'(bus.stack_empty), 32'(m_stk.size() == 0));
        chk({tag, ".err"},   32'(bus.stack_err),   32'(m_err));
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    // Apply current inputs for one clock, advance the model, then check.
    task automatic tick(input string tag);
        if (bus.en) begin
            if (bus.call) begin
                if (m_stk.size() == DEPTH) begin
                    m_err = 1'b1;
                    m_pc  = m_pc + 1'b1;
                end else begin
                    m_stk.push_back(WIDTH'(m_pc + 1'b1));
                    m_pc = bus.jmp_addr;
                end
            end else if (bus.ret) begin
                if (m_stk.size() == 0) begin
                    m_err = 1'b1;
                    m_pc  = m_pc + 1'b1;
                end else begin
                    void'(m_stk.pop_back());
                    m_pc = bus.jmp_addr;
                end
            end else if (bus.jmp_take) begin
                m_pc = bus.jmp_addr;
            end else begin
                m_pc = m_pc + 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic en, input logic c, input logic r,
                         input logic j, input logic [WIDTH-1:0] a);
        bus.en = en; bus.call = c; bus.ret = r; bus.jmp_take = j; bus.jmp_addr = a;
    endtask

    // Asynchronous reset pulse away from the clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        model_reset();
        #2;
        do_reset();

        // Idle counting 1..5
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) tick("idle");
        chk("idle.pc5", 32'(bus.pc), 32'h5);

        // CALL then RET
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h10); tick("jmp10");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h40); tick("call40");
        chk("call40.lr", 32'(bus.lr_addr), 32'h11);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h11); tick("ret11");
        chk("ret11.pc", 32'(bus.pc), 32'h11);

        // Fill the stack and overflow
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h02); tick("jmp02");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h20 + 8'(i) * 8'h10));
            tick("fill");
        end
        chk("ovf.pc",  32'(bus.pc),        32'h51);
        chk("ovf.err", 32'(bus.stack_err), 32'h1);
        chk("ovf.lr",  32'(bus.lr_addr),   32'h41);
        do_reset();

        // RET on empty, error stays sticky
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h07); tick("jmp07");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h99); tick("uflow");
        chk("uflow.pc", 32'(bus.pc), 32'h08);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h60); tick("sticky1");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h70); tick("sticky2");
        do_reset();

        // PC wrap on push and on increment
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF); tick("jmpFF");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h80); tick("callwrap");
        chk("callwrap.lr", 32'(bus.lr_addr), 32'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF); tick("jmpFF2");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); tick("incwrap");
        chk("incwrap.pc", 32'(bus.pc), 32'h00);

        // Priority: all three commands -> push only
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h33); tick("prio");
        chk("prio.pc", 32'(bus.pc), 32'h33);
        chk("prio.sp", 32'(bus.sp), 32'h2);

        // Stall with call held
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
        for (int i = 0; i < 3; i++) tick("stall");

        // Reset mid-cycle, checked without a clock edge
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h44);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async.pc", 32'(bus.pc), 32'h0);
        chk("async.sp", 32'(bus.sp), 32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        // The call above was sampled at that edge with rst_n high
        m_stk.push_back(8'h01);
        m_pc = 8'h44;
        check_all("postrst");

        // Random commands against the model
        for (int n = 0; n < 400; n++) begin
            if (n % 80 == 79) do_reset();
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  WIDTH'($urandom));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
